// File: rtl/i2c_target.sv
// I2C target: oversampled scl/sda, START/STOP detection,
// byte receive on write and byte return on read, open-drain sda.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_d;

  logic sda_in, scl_rise, scl_fall, bus_start, bus_stop;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Index 1 is the synchronised value, index 2 its previous sample.
  assign sda_in    = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign bus_start = scl_sync_q[1] & scl_sync_q[2]
                   & ~sda_sync_q[1] & sda_sync_q[2];
  assign bus_stop  = scl_sync_q[1] & scl_sync_q[2]
                   & sda_sync_q[1] & ~sda_sync_q[2];

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl};
    sda_sync_d = {sda_sync_q[1:0], sda};
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    if (bus_start) begin
      state_d  = ST_ADDR;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (bus_stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d          = {shift_q[6:0], sda_in};
            {done_d, cnt_d}  = {1'b0, cnt_q} + 4'd1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            sda_oe_d = 1'b0;
            if (shift_q[0]) begin
              state_d = ST_RX;
            end else begin
              tx_load_d = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              state_d   = ST_TX;
            end
          end
        end
        ST_RX: begin
          if (scl_rise) begin
            shift_d         = {shift_q[6:0], sda_in};
            {done_d, cnt_d} = {1'b0, cnt_q} + 4'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {shift_q[6:0], sda_in};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            state_d  = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            {done_d, cnt_d} = {1'b0, cnt_q} + 4'd1;
          end else if (scl_fall) begin
            if (done_q) begin
              done_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && sda_in) begin
            state_d = ST_IGNORE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            tx_load_d = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            cnt_d     = 3'd0;
            done_d    = 1'b0;
            state_d   = ST_TX;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_d;
  assign busy     = busy_q;
  assign state    = {1'b0, state_q};

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller drives
// scl/sda and checks ACKs, bytes, pulses and FSM state.
module tb_i2c_target;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_c;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  logic [3:0] state;
  wire        sda;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int txl_cnt = 0;
  int drove = 0;

  pullup (sda);
  assign sda = sda_c ? 1'bz : 1'b0;

  i2c_target #(.ADDR(7'h2A)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_load(tx_load), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (tx_load) txl_cnt++;
    if (sda_c && sda === 1'b0) drove++;
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_w(input logic b);
    sda_c = b;
    wq(Q); scl = 1'b1;
    wq(2 * Q); scl = 1'b0;
    wq(Q);
  endtask

  task automatic bit_r(output logic b);
    sda_c = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wq(Q); scl = 1'b0;
    wq(Q);
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask

  task automatic byte_r(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) bit_r(d[i]);
    bit_w(ack);
  endtask

  task automatic bus_start();
    sda_c = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); sda_c = 1'b0;
    wq(Q); scl = 1'b0;
    wq(Q);
  endtask

  task automatic bus_stop();
    sda_c = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); sda_c = 1'b1;
    wq(2 * Q);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wq(5);
    reset = 1'b0;
    wq(5);
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_tx_load got %b want 0", tx_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda got %b want 1", sda); end
  endtask

  task automatic test_write();
    logic ack;
    int rx0;
    rx0 = rxv_cnt;
    bus_start();
    byte_w(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy); end
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL wr_state_rx got %0d want 3", state); end
    byte_w(8'hC3, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack got %b want 0", ack); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL wr_rx_data got %h want c3", rx_data); end
    checks++; if (rxv_cnt - rx0 !== 1) begin errors++; $display("FAIL wr_rx_valid_cnt got %0d want 1", rxv_cnt - rx0); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b want 0", busy); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL wr_state_stop got %0d want 0", state); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b;
    int tl0;
    tl0 = txl_cnt;
    tx_data = 8'hA5;
    bus_start();
    byte_w(8'h54, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    checks++; if (txl_cnt - tl0 !== 1) begin errors++; $display("FAIL rd_tx_load1 got %0d want 1", txl_cnt - tl0); end
    tx_data = 8'h3C;
    byte_r(b, 1'b0);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL rd_byte1 got %h want a5", b); end
    byte_r(b, 1'b1);
    checks++; if (b !== 8'h3C) begin errors++; $display("FAIL rd_byte2 got %h want 3c", b); end
    checks++; if (txl_cnt - tl0 !== 2) begin errors++; $display("FAIL rd_tx_load2 got %0d want 2", txl_cnt - tl0); end
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL rd_ignore got %0d want 7", state); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rd_sda_rel got %b want 1", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy got %b want 0", busy); end
    bus_stop();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rd_state_stop got %0d want 0", state); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int rx0, dr0;
    rx0 = rxv_cnt;
    dr0 = drove;
    bus_start();
    byte_w(8'h56, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_ack got %b want 1", ack); end
    checks++; if (state !== 4'd7) begin errors++; $display("FAIL mm_state got %0d want 7", state); end
    byte_w(8'h12, ack);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy got %b want 0", busy); end
    bus_stop();
    checks++; if (drove - dr0 !== 0) begin errors++; $display("FAIL mm_sda_driven got %0d want 0", drove - dr0); end
    checks++; if (rxv_cnt - rx0 !== 0) begin errors++; $display("FAIL mm_rx_valid got %0d want 0", rxv_cnt - rx0); end
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] b;
    int rx0;
    rx0 = rxv_cnt;
    tx_data = 8'h77;
    bus_start();
    byte_w(8'h55, ack);
    byte_w(8'h11, ack);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_data got %h want 11", rx_data); end
    bus_start();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL rs_state_addr got %0d want 1", state); end
    byte_w(8'h54, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b want 0", ack); end
    byte_r(b, 1'b1);
    checks++; if (b !== 8'h77) begin errors++; $display("FAIL rs_read got %h want 77", b); end
    bus_stop();
    checks++; if (rxv_cnt - rx0 !== 1) begin errors++; $display("FAIL rs_rx_valid got %0d want 1", rxv_cnt - rx0); end
  endtask

  task automatic test_abort();
    logic ack;
    int rx0;
    bus_start();
    byte_w(8'h55, ack);
    rx0 = rxv_cnt;
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
    bus_stop();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL ab_state got %0d want 0", state); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL ab_sda got %b want 1", sda); end
    checks++; if (rxv_cnt - rx0 !== 0) begin errors++; $display("FAIL ab_rx_valid got %0d want 0", rxv_cnt - rx0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    logic [7:0] d;
    d = 8'hF0;
    bus_start();
    byte_w(8'h55, ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    sda_c = 1'b1;
    #1;
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rm_ack_drive got %b want 0", sda); end
    reset = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda got %b want 1", sda); end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rm_state got %0d want 0", state); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data got %h want 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    wq(2);
    reset = 1'b0;
    wq(4);
    bus_start();
    byte_w(8'h55, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_addr_ack got %b want 0", ack); end
    byte_w(8'hA7, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_data_ack got %b want 0", ack); end
    checks++; if (rx_data !== 8'hA7) begin errors++; $display("FAIL rm_rx_data2 got %h want a7", rx_data); end
    bus_stop();
  endtask

  initial begin
    reset = 1'b1;
    scl = 1'b1;
    sda_c = 1'b1;
    tx_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_rep_start();
    test_abort();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) for the on-chip two-wire bus, the bus-side counterpart to the team's I2C controller. Oversamples `scl`/`sda` on the system clock and detects START and STOP. On its own 7-bit address it receives bytes from the controller (write) or returns bytes supplied by local logic (read). It drives `sda` open-drain, low or Z only, and never drives `scl`.

## Interface
- `ADDR`, default 7'h2A: 7-bit target address matched against the address byte.
- `clk  in  1`: system clock; frequency must be at least 8x the `scl` frequency.
- `reset  in  1`: asynchronous, active-high reset.
- `scl  in  1`: bus clock from the controller.
- `sda  inout  1`: bus data; the block drives 1'b0 when `sda_oe` is high, otherwise 1'bz.
- `tx_data  in  8`: byte to return during a controller read; sampled on `tx_load`.
- `rx_data  out  8`: last byte received in a controller write.
- `rx_valid  out  1`: one-`clk` pulse when `rx_data` updates.
- `tx_load  out  1`: one-`clk` pulse when `tx_data` is captured.
- `busy  out  1`: high from an address-matched START until STOP, NACK or mismatch.
- `state  out  4`: current FSM state, for debug.

## Operation
- **Input synchronisation**
  - `scl` and `sda` pass through a 2-flop synchroniser, then a third flop for edge detection.
  - All decisions use the synchronised values only. Z on `sda` is sampled as 1.
- **Bus events**
  - START: `sda` falls while `scl` is high.
  - STOP: `sda` rises while `scl` is high.
  - Data bits: sampled on `scl` rise, changed by the target only on `scl` fall.
- **Bit order and R/W encoding**
  - Bytes are MSB first.
  - The address byte is 7 address bits then the R/W bit. R/W = 1 means the controller writes; R/W = 0 means the controller reads. This encoding is decided.
- **FSM states**
  - IDLE (0): waits for START.
  - ADDR (1): shifts in 8 bits. On the 8th `scl` fall: address match goes to ADDR_ACK, mismatch goes to IGNORE.
  - ADDR_ACK (2): `sda_oe` = 1 from the 8th `scl` fall to the 9th `scl` fall. At the 9th fall:
    - R/W = 1: go to RX.
    - R/W = 0: pulse `tx_load`, load the shifter with `tx_data`, go to TX.
  - RX (3): shifts in 8 bits. On the 8th `scl` rise, `rx_data` takes the byte and `rx_valid` pulses. At the 8th fall, go to RX_ACK.
  - RX_ACK (4): `sda_oe` = 1 until the next `scl` fall, then return to RX.
  - TX (5): `sda_oe` = ~shifter MSB, updated at each `scl` fall. At the 8th fall, release `sda` and go to TX_ACK.
  - TX_ACK (6): samples `sda` on the `scl` rise.
    - 0 (ACK): at the next `scl` fall, pulse `tx_load`, reload the shifter, go to TX.
    - 1 (NACK): go to IGNORE.
  - IGNORE (7): `sda_oe` = 0 and `busy` = 0; waits for START or STOP.
- **Bus-event priority** (overrides all of the above)
  - START in any state: go to ADDR, clear the bit counter, set `sda_oe` = 0. This covers repeated START.
  - STOP in any state: go to IDLE, set `sda_oe` = 0.
  - Simultaneous START and STOP detection cannot occur; START is checked first.
- **Bit counter**: 3 bits plus a done flag. It wraps at 8 and is cleared on entry to ADDR, RX and TX.

## Timing
- **Reset values**: `state` = IDLE, `sda_oe` = 0 (`sda` = Z), `rx_data` = 8'h00, `rx_valid` = 0, `tx_load` = 0, `busy` = 0, shifter = 0, synchroniser flops = 1.
- **Latency from a bus edge to the block's response**: 3 `clk` cycles (2 synchroniser + 1 edge detect).
  - `sda_oe` changes 3 `clk` after the synchronised `scl` fall.
  - This stays inside the `scl` low phase as long as `clk` ≥ 8x `scl`.
- **Pulse timing**
  - `rx_valid` is high exactly 1 `clk`, in the same cycle `rx_data` changes.
  - `tx_load` is high exactly 1 `clk`. `tx_data` must be stable on that cycle; the shifter captures it at the end of the cycle.
- **`busy`**
  - Rises on the ADDR→ADDR_ACK transition when the address matches.
  - Falls on STOP, on entry to IGNORE, or on reset.
- **Reset mid-transfer**: outputs return to reset values immediately; `sda` is released within the same cycle.

## Test plan
- **Write one byte**: START, address 0x2A with R/W = 1 (byte 0x55), data 0xC3, STOP.
  - Target ACKs both bytes (`sda` = 0 during both 9th clocks).
  - `rx_valid` pulses once with `rx_data` = 0xC3; `busy` falls at STOP.
- **Read two bytes**: START, byte 0x54 (R/W = 0). `tx_data` = 0xA5, then 0x3C.
  - Controller ACKs the first byte and NACKs the second.
  - Bus shows 0xA5 then 0x3C; `tx_load` pulses exactly twice.
  - `sda` is released after the NACK; the FSM is in IGNORE until STOP.
- **Address mismatch**: byte 0x56 (address 0x2B).
  - No ACK; `sda` stays Z for the whole transfer; no `rx_valid`; `busy` = 0.
- **Repeated START**: write byte 0x11, then START without STOP, then read.
  - `rx_data` = 0x11; FSM re-enters ADDR; the read returns current `tx_data`.
- **Abort by STOP**: STOP after the 4th data bit of a write.
  - FSM goes to IDLE, `sda` = Z, no `rx_valid`.
- **Reset mid-ACK**: assert `reset` while the target holds `sda` low in RX_ACK.
  - `sda` = Z in the same cycle; all outputs at reset values; a following full write works normally.
